// File: rtl/fpdiv_pkg.sv
// Shared state and select encodings for the Goldschmidt
// divider controller.
package fpdiv_pkg;

   localparam int ITER_W_DEFAULT = 4;

   typedef enum logic [2:0] {
      IDLE,
      N_MUL,
      D_MUL,
      A_ITER,
      B_ITER,
      REM,
      DONE
   } state_t;

   localparam logic [1:0] MUX3_IA  = 2'b00;
   localparam logic [1:0] MUX3_C   = 2'b01;
   localparam logic [1:0] MUX3_REM = 2'b10;

   localparam logic [1:0] MUX4_N = 2'b00;
   localparam logic [1:0] MUX4_D = 2'b01;
   localparam logic [1:0] MUX4_A = 2'b10;
   localparam logic [1:0] MUX4_B = 2'b11;

endpackage

// File: rtl/fpdiv_ctrl.sv
// Moore sequencer for the Goldschmidt divider datapath.
// Define FPDIV_CTRL_ABORT_EN to add the abort input.
module fpdiv_ctrl
   import fpdiv_pkg::*;
#(
   parameter int ITERS  = 6,
   parameter int ITER_W = ITER_W_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
`ifdef FPDIV_CTRL_ABORT_EN
   input  logic              abort,
`endif
   output logic [1:0]        sel_mux3,
   output logic [1:0]        sel_mux4,
   output logic              en_a,
   output logic              en_b,
   output logic              en_rem,
   output logic              busy,
   output logic              done,
   output logic [ITER_W-1:0] iter
);

   state_t            r_state;
   logic [ITER_W-1:0] r_iter;
   logic              w_busy;
   logic              w_abort;

   assign w_busy = (r_state != IDLE)
                && (r_state != DONE);

`ifdef FPDIV_CTRL_ABORT_EN
   assign w_abort = abort && w_busy;
`else
   assign w_abort = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset || w_abort) begin
         r_state <= IDLE;
         r_iter  <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_state <= N_MUL;
                  r_iter  <= ITER_W'(1);
               end
            end
            N_MUL: r_state <= D_MUL;
            D_MUL: begin
               if (ITERS == 1) begin
                  r_state <= REM;
               end else begin
                  r_state <= A_ITER;
                  r_iter  <= ITER_W'(2);
               end
            end
            A_ITER: r_state <= B_ITER;
            B_ITER: begin
               if (r_iter == ITER_W'(ITERS)) begin
                  r_state <= REM;
               end else begin
                  r_state <= A_ITER;
                  r_iter  <= r_iter + 1'b1;
               end
            end
            REM: r_state <= DONE;
            DONE: begin
               // back-to-back issue skips IDLE
               if (start) begin
                  r_state <= N_MUL;
                  r_iter  <= ITER_W'(1);
               end else begin
                  r_state <= IDLE;
                  r_iter  <= '0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_iter  <= '0;
            end
         endcase
      end
   end

   always_comb begin
      sel_mux3 = MUX3_IA;
      sel_mux4 = MUX4_N;
      en_a     = 1'b0;
      en_b     = 1'b0;
      en_rem   = 1'b0;
      unique case (r_state)
         N_MUL: begin
            en_a = 1'b1;
         end
         D_MUL: begin
            sel_mux4 = MUX4_D;
            en_b     = 1'b1;
         end
         A_ITER: begin
            sel_mux4 = MUX4_A;
            sel_mux3 = MUX3_C;
            en_a     = 1'b1;
         end
         B_ITER: begin
            sel_mux4 = MUX4_B;
            sel_mux3 = MUX3_C;
            en_b     = 1'b1;
         end
         REM: begin
            sel_mux4 = MUX4_A;
            sel_mux3 = MUX3_REM;
            en_rem   = 1'b1;
         end
         default: ;
      endcase
   end

   assign busy = w_busy;
   assign done = (r_state == DONE);
   assign iter = r_iter;

endmodule
